// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, instruction field
// positions, T-step state encoding and an opcode classifier.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU    = 3'd0,
        CL_MULDIV = 3'd1,
        CL_UNARY  = 3'd2,
        CL_NOP    = 3'd3,
        CL_HALT   = 3'd4
    } op_class_t;

    // Undefined opcodes fall into the nop class so they retire harmlessly.
    function automatic op_class_t classify(input logic [4:0] op);
        op_class_t cls;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL: cls = CL_ALU;
            OP_MUL, OP_DIV:                  cls = CL_MULDIV;
            OP_NEG, OP_NOT:                  cls = CL_UNARY;
            OP_HALT:                         cls = CL_HALT;
            default:                         cls = CL_NOP;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/reg_onehot_decoder.sv
// Register number to one-hot enable vector; all-zero when not enabled.
module reg_onehot_decoder #(
    parameter int NREGS = 16
) (
    input  logic [3:0]       sel,
    input  logic             en,
    output logic [NREGS-1:0] onehot
);

    // One comparator per register line.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NREGS; i++) begin
            onehot[i] = en && (sel == 4'(i));
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-step control unit: one state register stepping fetch/execute and a
// combinational decode of state plus instruction into datapath strobes.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NREGS = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [31:0]      ir,
    input  logic             stop,
    output logic [NREGS-1:0] rin,
    output logic [NREGS-1:0] rout,
    output logic             PCout,
    output logic             PCin,
    output logic             incPC,
    output logic             MARin,
    output logic             MDRin,
    output logic             MDRout,
    output logic             Read,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             ZLowOut,
    output logic             ZHighOut,
    output logic             HIin,
    output logic             LOin,
    output logic [4:0]       alu_op,
    output logic             run
);

    state_t     state_r;
    logic       stop_pend_r;
    logic [4:0] opcode_s;
    logic [3:0] ra_s, rb_s, rc_s;
    op_class_t  cls_s;
    logic       last_step_s;
    logic       halt_req_s;
    state_t     fin_state_s;
    logic       rin_en_s, rout_en_s;
    logic [3:0] rin_sel_s, rout_sel_s;
    logic       unused_ir_s;

    assign opcode_s    = ir[OPC_MSB:OPC_LSB];
    assign ra_s        = ir[RA_MSB:RA_LSB];
    assign rb_s        = ir[RB_MSB:RB_LSB];
    assign rc_s        = ir[RC_MSB:RC_LSB];
    assign unused_ir_s = ^ir[RC_LSB-1:0];
    assign cls_s       = classify(opcode_s);
    // A stop pulse is remembered so it still takes effect at the instruction boundary.
    assign halt_req_s  = stop || stop_pend_r;
    assign fin_state_s = (cls_s == CL_HALT || halt_req_s) ? ST_HALT : ST_T0;

    // Identify the final execute step of the current instruction class.
    always_comb begin
        last_step_s = 1'b0;
        case (state_r)
            ST_T3:   last_step_s = (cls_s == CL_NOP) || (cls_s == CL_HALT);
            ST_T4:   last_step_s = (cls_s == CL_UNARY);
            ST_T5:   last_step_s = (cls_s == CL_ALU);
            ST_T6:   last_step_s = (cls_s == CL_MULDIV);
            default: last_step_s = 1'b0;
        endcase
    end

    // Step sequencing and pending-stop capture.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r     <= ST_RST;
            stop_pend_r <= 1'b0;
        end else begin
            stop_pend_r <= halt_req_s && !last_step_s;
            case (state_r)
                ST_RST:  state_r <= ST_T0;
                ST_T0:   state_r <= ST_T1;
                ST_T1:   state_r <= ST_T2;
                ST_T2:   state_r <= ST_T3;
                ST_T3:   state_r <= last_step_s ? fin_state_s : ST_T4;
                ST_T4:   state_r <= last_step_s ? fin_state_s : ST_T5;
                ST_T5:   state_r <= last_step_s ? fin_state_s : ST_T6;
                ST_T6:   state_r <= fin_state_s;
                ST_HALT: state_r <= ST_HALT;
                default: state_r <= ST_RST;
            endcase
        end
    end

    // Strobe decode from the current step and the instruction fields.
    always_comb begin
        {PCout, PCin, incPC, MARin, MDRin, MDRout, Read, IRin} = 8'h00;
        {Yin, Zin, ZLowOut, ZHighOut, HIin, LOin}              = 6'h00;
        alu_op     = 5'b00000;
        rin_en_s   = 1'b0;
        rin_sel_s  = 4'd0;
        rout_en_s  = 1'b0;
        rout_sel_s = 4'd0;
        run        = (state_r != ST_RST) && (state_r != ST_HALT);
        case (state_r)
            ST_T0: {PCout, MARin, incPC, Zin} = 4'hF;
            ST_T1: {ZLowOut, PCin, Read, MDRin} = 4'hF;
            ST_T2: {MDRout, IRin} = 2'b11;
            ST_T3: begin
                case (cls_s)
                    CL_ALU:    begin rout_en_s = 1'b1; rout_sel_s = rb_s; Yin = 1'b1; end
                    CL_MULDIV: begin rout_en_s = 1'b1; rout_sel_s = ra_s; Yin = 1'b1; end
                    CL_UNARY:  begin rout_en_s = 1'b1; rout_sel_s = rb_s; Zin = 1'b1; alu_op = opcode_s; end
                    default:   rout_en_s = 1'b0;
                endcase
            end
            ST_T4: begin
                case (cls_s)
                    CL_ALU:    begin rout_en_s = 1'b1; rout_sel_s = rc_s; Zin = 1'b1; alu_op = opcode_s; end
                    CL_MULDIV: begin rout_en_s = 1'b1; rout_sel_s = rb_s; Zin = 1'b1; alu_op = opcode_s; end
                    CL_UNARY:  begin ZLowOut = 1'b1; rin_en_s = 1'b1; rin_sel_s = ra_s; end
                    default:   rout_en_s = 1'b0;
                endcase
            end
            ST_T5: begin
                case (cls_s)
                    CL_ALU:    begin ZLowOut = 1'b1; rin_en_s = 1'b1; rin_sel_s = ra_s; end
                    CL_MULDIV: begin ZLowOut = 1'b1; LOin = 1'b1; end
                    default:   rin_en_s = 1'b0;
                endcase
            end
            ST_T6: begin
                case (cls_s)
                    CL_MULDIV: begin ZHighOut = 1'b1; HIin = 1'b1; end
                    default:   rin_en_s = 1'b0;
                endcase
            end
            default: run = run;
        endcase
    end

    reg_onehot_decoder #(.NREGS(NREGS)) u_rin_dec (
        .sel    (rin_sel_s),
        .en     (rin_en_s),
        .onehot (rin)
    );

    reg_onehot_decoder #(.NREGS(NREGS)) u_rout_dec (
        .sel    (rout_sel_s),
        .en     (rout_en_s),
        .onehot (rout)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus queues the expected output
// vector for each step, a negedge monitor pops and compares.
module tb_control_sequencer;

    logic        clk;
    logic        clr;
    logic [31:0] ir;
    logic        stop;
    logic [15:0] rin, rout;
    logic        PCout, PCin, incPC, MARin, MDRin, MDRout, Read, IRin;
    logic        Yin, Zin, ZLowOut, ZHighOut, HIin, LOin;
    logic [4:0]  alu_op;
    logic        run;

    control_sequencer #(.NREGS(16)) dut (
        .clk(clk), .clr(clr), .ir(ir), .stop(stop),
        .rin(rin), .rout(rout),
        .PCout(PCout), .PCin(PCin), .incPC(incPC), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .ZLowOut(ZLowOut), .ZHighOut(ZHighOut),
        .HIin(HIin), .LOin(LOin), .alu_op(alu_op), .run(run)
    );

    localparam logic [13:0] S_PCOUT  = 14'h2000;
    localparam logic [13:0] S_PCIN   = 14'h1000;
    localparam logic [13:0] S_INCPC  = 14'h0800;
    localparam logic [13:0] S_MARIN  = 14'h0400;
    localparam logic [13:0] S_MDRIN  = 14'h0200;
    localparam logic [13:0] S_MDROUT = 14'h0100;
    localparam logic [13:0] S_READ   = 14'h0080;
    localparam logic [13:0] S_IRIN   = 14'h0040;
    localparam logic [13:0] S_YIN    = 14'h0020;
    localparam logic [13:0] S_ZIN    = 14'h0010;
    localparam logic [13:0] S_ZLO    = 14'h0008;
    localparam logic [13:0] S_ZHI    = 14'h0004;
    localparam logic [13:0] S_HIIN   = 14'h0002;
    localparam logic [13:0] S_LOIN   = 14'h0001;

    typedef struct {
        logic [51:0] v;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur_e;
    int          checks = 0;
    int          errors = 0;
    logic [51:0] act;

    assign act = {run, rin, rout, PCout, PCin, incPC, MARin, MDRin, MDRout, Read, IRin,
                  Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, alu_op};

    function automatic logic [51:0] mk(input logic r, input logic [15:0] ri,
                                       input logic [15:0] ro, input logic [13:0] s,
                                       input logic [4:0] a);
        return {r, ri, ro, s, a};
    endfunction

    function automatic logic [31:0] mkir(input logic [4:0] op, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    logic [51:0] zero_v, t0_v, t1_v, t2_v, idle_v;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: compare DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            cur_e = exp_q.pop_front();
            checks++;
            if (act !== cur_e.v) begin
                errors++;
                $display("FAIL %s got %h exp %h", cur_e.name, act, cur_e.v);
            end
        end
    end

    task automatic expect_cycle(input logic [51:0] v, input string n);
        exp_t e;
        @(posedge clk);
        #1;
        e.v    = v;
        e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic fetch(input logic [31:0] new_ir, input string n);
        expect_cycle(t0_v, {n, "_T0"});
        ir = new_ir;
        expect_cycle(t1_v, {n, "_T1"});
        expect_cycle(t2_v, {n, "_T2"});
    endtask

    initial begin
        zero_v = '0;
        t0_v   = mk(1'b1, 16'h0, 16'h0, S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 5'b00000);
        t1_v   = mk(1'b1, 16'h0, 16'h0, S_ZLO | S_PCIN | S_READ | S_MDRIN, 5'b00000);
        t2_v   = mk(1'b1, 16'h0, 16'h0, S_MDROUT | S_IRIN, 5'b00000);
        idle_v = mk(1'b1, 16'h0, 16'h0, 14'h0000, 5'b00000);

        clr  = 1'b0;
        stop = 1'b0;
        ir   = 32'h0;
        repeat (3) expect_cycle(zero_v, "reset");
        clr = 1'b1;

        fetch(mkir(5'b00011, 4'd0, 4'd4, 4'd5), "add");
        expect_cycle(mk(1'b1, 16'h0000, 16'h0010, S_YIN, 5'b00000), "add_T3");
        expect_cycle(mk(1'b1, 16'h0000, 16'h0020, S_ZIN, 5'b00011), "add_T4");
        expect_cycle(mk(1'b1, 16'h0001, 16'h0000, S_ZLO, 5'b00000), "add_T5");

        fetch(mkir(5'b01111, 4'd2, 4'd3, 4'd0), "mul");
        expect_cycle(mk(1'b1, 16'h0000, 16'h0004, S_YIN, 5'b00000), "mul_T3");
        expect_cycle(mk(1'b1, 16'h0000, 16'h0008, S_ZIN, 5'b01111), "mul_T4");
        expect_cycle(mk(1'b1, 16'h0000, 16'h0000, S_ZLO | S_LOIN, 5'b00000), "mul_T5");
        expect_cycle(mk(1'b1, 16'h0000, 16'h0000, S_ZHI | S_HIIN, 5'b00000), "mul_T6");

        fetch(mkir(5'b10010, 4'd7, 4'd1, 4'd0), "not");
        expect_cycle(mk(1'b1, 16'h0000, 16'h0002, S_ZIN, 5'b10010), "not_T3");
        expect_cycle(mk(1'b1, 16'h0080, 16'h0000, S_ZLO, 5'b00000), "not_T4");

        fetch(mkir(5'b00100, 4'd15, 4'd14, 4'd13), "sub");
        expect_cycle(mk(1'b1, 16'h0000, 16'h4000, S_YIN, 5'b00000), "sub_T3");
        expect_cycle(mk(1'b1, 16'h0000, 16'h2000, S_ZIN, 5'b00100), "sub_T4");
        expect_cycle(mk(1'b1, 16'h8000, 16'h0000, S_ZLO, 5'b00000), "sub_T5");

        fetch(mkir(5'b11010, 4'd1, 4'd2, 4'd3), "nop");
        expect_cycle(idle_v, "nop_T3");
        fetch(mkir(5'b11111, 4'd1, 4'd2, 4'd3), "undef");
        expect_cycle(idle_v, "undef_T3");

        fetch(mkir(5'b11011, 4'd0, 4'd0, 4'd0), "halt");
        expect_cycle(idle_v, "halt_T3");
        repeat (10) expect_cycle(zero_v, "halted");

        clr = 1'b0;
        expect_cycle(zero_v, "reset2");
        clr = 1'b1;

        // stop is high only across the T4->T5 edge; the request must survive to T5's end.
        fetch(mkir(5'b00011, 4'd3, 4'd1, 4'd2), "stopadd");
        expect_cycle(mk(1'b1, 16'h0000, 16'h0002, S_YIN, 5'b00000), "stopadd_T3");
        expect_cycle(mk(1'b1, 16'h0000, 16'h0004, S_ZIN, 5'b00011), "stopadd_T4");
        stop = 1'b1;
        expect_cycle(mk(1'b1, 16'h0008, 16'h0000, S_ZLO, 5'b00000), "stopadd_T5");
        stop = 1'b0;
        repeat (2) expect_cycle(zero_v, "stop_halted");

        clr = 1'b0;
        expect_cycle(zero_v, "reset3");
        clr = 1'b1;

        fetch(mkir(5'b10000, 4'd1, 4'd2, 4'd0), "div");
        expect_cycle(mk(1'b1, 16'h0000, 16'h0002, S_YIN, 5'b00000), "div_T3");
        @(posedge clk);
        #1;
        clr = 1'b0;
        exp_q.push_back('{zero_v, "div_abort"});
        expect_cycle(zero_v, "div_abort_hold");
        clr = 1'b1;
        expect_cycle(t0_v, "resume_T0");
        expect_cycle(t1_v, "resume_T1");

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
